vga_timing_monitor: RTL and testbench



---
 rtl/vga_timing_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// Passive VGA timing monitor: recovers pixel coordinates, checks line/frame timing, locks, and checksums each frame.
// Optional build macro VGA_MON_CRC_EN swaps the additive frame sum for a CRC-16-CCITT over R,G,B bytes.
module vga_timing_monitor #(
    parameter int FRONT_PORCH_H = 40,
    parameter int BACK_PORCH_H  = 88,
    parameter int SYNC_PULSE_H  = 128,
    parameter int VISIBLE_H     = 800,
    parameter int FRONT_PORCH_V = 1,
    parameter int BACK_PORCH_V  = 23,
    parameter int SYNC_PULSE_V  = 4,
    parameter int VISIBLE_V     = 600,
    parameter int SYNC_POL      = 1,
    parameter int LOCK_FRAMES   = 2,
    parameter int CNTR_WIDTH_H  = 11,
    parameter int CNTR_WIDTH_V  = 10
) (
    input  logic                    VGA_CLK,
    input  logic                    RESET,
    input  logic                    VGA_HS,
    input  logic                    VGA_VS,
    input  logic                    VGA_BLANK_N,
    input  logic [7:0]              VGA_R,
    input  logic [7:0]              VGA_G,
    input  logic [7:0]              VGA_B,
    input  logic                    CLEAR_ERR,
    output logic [CNTR_WIDTH_H-1:0] CounterX,
    output logic [CNTR_WIDTH_V-1:0] CounterY,
    output logic                    PixValid,
    output logic [23:0]             PixRGB,
    output logic                    Locked,
    output logic                    FrameDone,
    output logic [23:0]             FrameSum,
    output logic [4:0]              ErrFlags,
    output logic [CNTR_WIDTH_H-1:0] MeasHTotal,
    output logic [CNTR_WIDTH_V-1:0] MeasVTotal
);

    localparam int HW = CNTR_WIDTH_H;
    localparam int VW = CNTR_WIDTH_V;
    localparam logic            POL     = (SYNC_POL != 0);
    localparam logic [HW-1:0]   H_TOTAL = HW'(FRONT_PORCH_H + BACK_PORCH_H + SYNC_PULSE_H + VISIBLE_H);
    localparam logic [HW-1:0]   HSW_C   = HW'(SYNC_PULSE_H);
    localparam logic [HW-1:0]   HVIS_C  = HW'(VISIBLE_H);
    localparam logic [HW-1:0]   H_ONE   = HW'(1);
    localparam logic [VW-1:0]   V_TOTAL = VW'(FRONT_PORCH_V + BACK_PORCH_V + SYNC_PULSE_V + VISIBLE_V);
    localparam logic [VW-1:0]   VSW_C   = VW'(SYNC_PULSE_V);
    localparam logic [VW-1:0]   V_ONE   = VW'(1);
    localparam logic [VW:0]     VVIS_C  = (VW+1)'(VISIBLE_V);
    localparam logic [7:0]      LOCK_C  = 8'(LOCK_FRAMES);

`ifdef VGA_MON_CRC_EN
    localparam logic [23:0] ACC_INIT = 24'h00FFFF;

    function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction
`else
    localparam logic [23:0] ACC_INIT = 24'h000000;
`endif

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state, state_n;
    logic [7:0] good_cnt, good_n;

    // stage 1: registered port inputs
    logic        hs_q, vs_q, blank_q, clr_q, hs_on_p, vs_on_p;
    logic [23:0] rgb_q;

    logic [HW-1:0] h_cnt, hs_w, x_cnt, x_pix;
    logic [VW-1:0] y_cnt, v_cnt, vs_w, y_mid, y_pix, v_meas;
    logic [VW:0]   frame_lines;
    logic          h_seen, line_act, la_mid, frame_err, frame_bad;
    logic [23:0]   acc, acc_base, acc_next;
    logic [4:0]    err_now;

    logic hs_on, vs_on, hs_lead, hs_trail, vs_lead, vs_trail, active, chk_en;
    assign hs_on    = (hs_q == POL);
    assign vs_on    = (vs_q == POL);
    assign hs_lead  = hs_on & ~hs_on_p;
    assign hs_trail = ~hs_on & hs_on_p;
    assign vs_lead  = vs_on & ~vs_on_p;
    assign vs_trail = ~vs_on & vs_on_p;
    assign active   = blank_q;
    assign chk_en   = (state != SEARCH);
    assign Locked   = (state == LOCKED);

    always_comb begin
        err_now     = '0;
        x_pix       = hs_lead ? '0 : x_cnt;
        la_mid      = line_act & ~hs_lead;
        y_mid       = y_cnt;
        // a coincident HS lead closes the old line before the frame closes
        if (hs_lead && line_act && y_cnt != '1) y_mid = y_cnt + V_ONE;
        y_pix       = vs_lead ? '0 : y_mid;
        frame_lines = {1'b0, y_mid} + {{VW{1'b0}}, la_mid};
        v_meas      = v_cnt + {{(VW-1){1'b0}}, hs_lead};
        if (chk_en) begin
            if (hs_lead && h_seen) begin
                if (h_cnt != H_TOTAL)                 err_now[0] = 1'b1;
                if (line_act && x_cnt != HVIS_C)      err_now[2] = 1'b1;
            end
            if (hs_trail && h_seen && hs_w != HSW_C)  err_now[1] = 1'b1;
            if (vs_lead) begin
                if (v_meas != V_TOTAL)                err_now[3] = 1'b1;
                if (frame_lines != VVIS_C)            err_now[2] = 1'b1;
            end
            if (vs_trail && vs_w != VSW_C)            err_now[3] = 1'b1;
            if (active && (hs_on || vs_on || x_pix == '1 || y_pix == '1))
                err_now[4] = 1'b1;
        end
        frame_bad = frame_err | (|err_now);
        acc_base  = vs_lead ? ACC_INIT : acc;
        acc_next  = acc_base;
`ifdef VGA_MON_CRC_EN
        if (active) acc_next = {8'h00, crc_px(acc_base[15:0], {rgb_q[7:0], rgb_q[15:8], rgb_q[23:16]})};
`else
        if (active) acc_next = acc_base + rgb_q;
`endif
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        case (state)
            SEARCH: if (vs_lead) begin
                state_n = MEASURE;
                good_n  = '0;
            end
            MEASURE: if (vs_lead) begin
                if (frame_bad) good_n = '0;
                else begin
                    good_n = good_cnt + 8'd1;
                    if (good_cnt + 8'd1 >= LOCK_C) state_n = LOCKED;
                end
            end
            LOCKED: if (|err_now) begin
                state_n = MEASURE;
                good_n  = '0;
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            hs_q <= ~POL;  vs_q <= ~POL;  blank_q <= 1'b0;  clr_q <= 1'b0;  rgb_q <= '0;
            hs_on_p <= 1'b0;  vs_on_p <= 1'b0;
            h_cnt <= '0;  hs_w <= '0;  x_cnt <= '0;  h_seen <= 1'b0;  line_act <= 1'b0;
            y_cnt <= '0;  v_cnt <= '0;  vs_w <= '0;  acc <= '0;  frame_err <= 1'b0;
            state <= SEARCH;  good_cnt <= '0;
            CounterX <= '0;  CounterY <= '0;  PixValid <= 1'b0;  PixRGB <= '0;
            FrameDone <= 1'b0;  FrameSum <= '0;  ErrFlags <= '0;
            MeasHTotal <= '0;  MeasVTotal <= '0;
        end else begin
            hs_q    <= VGA_HS;
            vs_q    <= VGA_VS;
            blank_q <= VGA_BLANK_N;
            clr_q   <= CLEAR_ERR;
            rgb_q   <= {VGA_B, VGA_G, VGA_R};
            hs_on_p <= hs_on;
            vs_on_p <= vs_on;

            if (hs_lead)            h_cnt <= H_ONE;
            else if (h_cnt != '1)   h_cnt <= h_cnt + H_ONE;
            if (hs_lead) begin
                h_seen <= 1'b1;
                if (h_seen) MeasHTotal <= h_cnt;
            end
            if (hs_lead)                     hs_w <= H_ONE;
            else if (hs_on && hs_w != '1)    hs_w <= hs_w + H_ONE;

            if (active) x_cnt <= (x_pix == '1) ? x_pix : x_pix + H_ONE;
            else        x_cnt <= x_pix;
            line_act <= (line_act & ~hs_lead & ~vs_lead) | active;
            y_cnt    <= y_pix;

            if (vs_lead)                          v_cnt <= '0;
            else if (hs_lead && v_cnt != '1)      v_cnt <= v_cnt + V_ONE;
            if (vs_lead)                                   vs_w <= hs_lead ? V_ONE : '0;
            else if (vs_on && hs_lead && vs_w != '1)       vs_w <= vs_w + V_ONE;

            acc       <= acc_next;
            frame_err <= vs_lead ? 1'b0 : frame_bad;
            FrameDone <= vs_lead & chk_en;
            if (vs_lead && chk_en) begin
                FrameSum   <= acc;
                MeasVTotal <= v_meas;
            end
            // a fresh error outranks a simultaneous clear
            ErrFlags <= (clr_q ? 5'b0 : ErrFlags) | err_now;

            PixValid <= active;
            if (active) begin
                CounterX <= x_pix;
                CounterY <= y_pix;
                PixRGB   <= rgb_q;
            end

            state    <= state_n;
            good_cnt <= good_n;
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a scaled-down raster (34x15 clocks/lines) so
// many frames fit in a short run; expected values are hand-derived from that raster.
module tb_vga_timing_monitor;

    localparam int HFP = 4, HBP = 6, HSW = 8, HVIS = 16, HT = HFP + HBP + HSW + HVIS;   // 34
    localparam int VFP = 1, VBP = 2, VSW = 2, VVIS = 10, VT = VFP + VBP + VSW + VVIS;   // 15
    localparam int HACT0 = HSW + HBP;   // first active column of a line
    localparam int VACT0 = VSW + VBP;   // first active line of a frame

    logic        VGA_CLK = 1'b0;
    logic        RESET, VGA_HS, VGA_VS, VGA_BLANK_N, CLEAR_ERR;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic [10:0] CounterX;
    logic [9:0]  CounterY;
    logic        PixValid, Locked, FrameDone;
    logic [23:0] PixRGB, FrameSum;
    logic [4:0]  ErrFlags;
    logic [10:0] MeasHTotal;
    logic [9:0]  MeasVTotal;

    vga_timing_monitor #(
        .FRONT_PORCH_H(HFP), .BACK_PORCH_H(HBP), .SYNC_PULSE_H(HSW), .VISIBLE_H(HVIS),
        .FRONT_PORCH_V(VFP), .BACK_PORCH_V(VBP), .SYNC_PULSE_V(VSW), .VISIBLE_V(VVIS),
        .SYNC_POL(1), .LOCK_FRAMES(2), .CNTR_WIDTH_H(11), .CNTR_WIDTH_V(10)
    ) dut (
        .VGA_CLK(VGA_CLK), .RESET(RESET), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .CLEAR_ERR(CLEAR_ERR), .CounterX(CounterX), .CounterY(CounterY),
        .PixValid(PixValid), .PixRGB(PixRGB), .Locked(Locked), .FrameDone(FrameDone),
        .FrameSum(FrameSum), .ErrFlags(ErrFlags), .MeasHTotal(MeasHTotal),
        .MeasVTotal(MeasVTotal)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int n_vec = 0, n_bad = 0, fd_cnt = 0, fd0;
    always @(negedge VGA_CLK) if (FrameDone) fd_cnt++;

    // what was driven one cycle back; the outputs show it after the next edge
    logic        p_vld = 1'b0;
    logic [10:0] p_x = '0;
    logic [9:0]  p_y = '0;
    logic [23:0] p_rgb = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        VGA_HS = 1'b0; VGA_VS = 1'b0; VGA_BLANK_N = 1'b0; CLEAR_ERR = 1'b0;
        VGA_R = '0; VGA_G = '0; VGA_B = '0;
        repeat (n) cyc;
        p_vld = 1'b0;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_xyv"},  {CounterX, CounterY, PixValid}, 0);
        chk({pfx, "_rgb"},  PixRGB, 0);
        chk({pfx, "_lfe"},  {Locked, FrameDone, ErrFlags}, 0);
        chk({pfx, "_sum"},  FrameSum, 0);
        chk({pfx, "_meas"}, {MeasHTotal, MeasVTotal}, 0);
    endtask

    // one raster frame starting with the VS lead; knobs inject the faults under test
    task automatic run_frame(input int nact, input int long_ln, input int short_ln,
                             input bit glitch, input bit grad, input bit clr, input int nlines);
        for (int v = 0; v < nlines; v++) begin
            int hlen, hsw;
            hlen = (v == long_ln)  ? HT + 1  : HT;
            hsw  = (v == short_ln) ? HSW - 1 : HSW;
            for (int h = 0; h < hlen; h++) begin
                logic act;
                act = (v >= VACT0) && (v < VACT0 + nact) && (h >= HACT0) && (h < HACT0 + HVIS);
                VGA_HS      = (h < hsw);
                VGA_VS      = (v < VSW);
                VGA_BLANK_N = act || (glitch && v == 0 && h == 20);
                VGA_R       = grad ? 8'(h - HACT0) : 8'd1;
                VGA_G       = grad ? 8'(v - VACT0) : 8'd0;
                VGA_B       = 8'd0;
                CLEAR_ERR   = clr && (v == VT - 1) && (h == 0);
                cyc;
                if (grad) begin
                    chk("pix_vld", PixValid, p_vld);
                    if (p_vld) begin
                        chk("pix_x", CounterX, p_x);
                        chk("pix_y", CounterY, p_y);
                        chk("pix_rgb", PixRGB, p_rgb);
                    end
                end
                p_vld = VGA_BLANK_N;
                p_x   = 11'(h - HACT0);
                p_y   = 10'(v - VACT0);
                p_rgb = {VGA_B, VGA_G, VGA_R};
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        idle(3);
        check_zero("rst");
        RESET = 1'b0;
        idle(3);

        // nominal frames: first VS lead leaves SEARCH, next two closes lock
        run_frame(VVIS, -1, -1, 0, 0, 0, VT);
        run_frame(VVIS, -1, -1, 0, 0, 0, VT);
        chk("lock_pre", Locked, 0);
        run_frame(VVIS, -1, -1, 0, 0, 0, VT);
        chk("fd_cnt", fd_cnt, 2);
        chk("fsum", FrameSum, 24'h0000A0);
        chk("htot", MeasHTotal, 34);
        chk("vtot", MeasVTotal, 15);
        chk("lock", Locked, 1);
        chk("err_clean", ErrFlags, 0);

        // one long line while locked
        run_frame(VVIS, 5, -1, 0, 0, 0, VT);
        chk("err_htot", ErrFlags, 5'b00001);
        chk("lock_drop", Locked, 0);
        run_frame(VVIS, -1, -1, 0, 0, 0, VT);
        run_frame(VVIS, -1, -1, 0, 0, 0, VT);
        chk("relock_pre", Locked, 0);
        run_frame(VVIS, -1, -1, 0, 0, 0, VT);
        chk("relock", Locked, 1);
        chk("err_sticky", ErrFlags, 5'b00001);
        run_frame(VVIS, -1, -1, 0, 0, 1, VT);
        chk("err_clr", ErrFlags, 0);
        chk("lock_h", Locked, 1);

        // short HS pulse, then BLANK_N glitch inside VS
        run_frame(VVIS, -1, 3, 0, 0, 0, VT);
        chk("err_hsw", ErrFlags, 5'b00010);
        run_frame(VVIS, -1, -1, 0, 0, 1, VT);
        chk("err_clr2", ErrFlags, 0);
        run_frame(VVIS, -1, -1, 1, 0, 0, VT);
        chk("err_blank", ErrFlags[4], 1);

        // gradient: coordinates and colour two cycles behind the ports
        run_frame(VVIS, -1, -1, 0, 1, 0, VT);

        // reset in the middle of a frame
        run_frame(VVIS, -1, -1, 0, 0, 0, 7);
        RESET = 1'b1; VGA_HS = 1'b0; VGA_VS = 1'b0; VGA_BLANK_N = 1'b0;
        cyc;
        check_zero("mid_rst");
        RESET = 1'b0;
        idle(5);
        fd0 = fd_cnt;
        run_frame(VVIS, -1, -1, 0, 0, 0, VT);
        chk("no_fd", fd_cnt, fd0);
        run_frame(VVIS, -1, -1, 0, 0, 0, VT);
        chk("fd_q", fd_cnt, fd0 + 1);
        chk("lock_q", Locked, 0);
        run_frame(VVIS, -1, -1, 0, 0, 0, VT);
        chk("lock_r", Locked, 1);

        // one active line short
        run_frame(VVIS - 1, -1, -1, 0, 0, 0, VT);
        run_frame(VVIS, -1, -1, 0, 0, 0, VT);
        chk("err_vis", ErrFlags, 5'b00100);
        chk("fsum_short", FrameSum, 24'h000090);
        chk("fd_t", fd_cnt, fd0 + 4);
        chk("lock_t", Locked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
